// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable pattern, overlap select, bit history
// window and a saturating match counter.
module seq_detector_param #(
  parameter int              W         = 10,
  parameter int              PLEN      = 4,
  parameter int              CNT_W     = 8,
  parameter logic [PLEN-1:0] RESET_PAT = PLEN'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             valid,
  input  logic [PLEN-1:0]  pattern,
  input  logic             load,
  input  logic             overlap,
  input  logic             clear,
  output logic             match,
  output logic [W-1:0]     d,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int             FW       = $clog2(PLEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PLEN);
  localparam logic [FW-1:0]  ARM_TH   = FW'(PLEN - 1);

  logic [PLEN-1:0] pat_reg;
  logic [FW-1:0]   fill;
  logic [PLEN-1:0] cand;
  logic [W-1:0]    d_shift;
  logic [FW-1:0]   fill_inc;
  logic            hit;

  assign cand     = {d[PLEN-2:0], data};
  assign d_shift  = {d[W-2:0], data};
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + FW'(1);
  assign armed    = (fill >= ARM_TH);
  // Only a plain valid cycle may complete a match; clear/load suppress evaluation.
  assign hit      = valid && !clear && !load && armed && (cand == pat_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d           <= '0;
      pat_reg     <= RESET_PAT;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      d           <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (load) begin
      // The shifted-in bit still lands in d but does not count toward fill.
      pat_reg <= pattern;
      fill    <= '0;
      match   <= 1'b0;
      if (valid) d <= d_shift;
    end else if (valid) begin
      d     <= d_shift;
      match <= hit;
      if (hit) begin
        if (match_count != {CNT_W{1'b1}}) match_count <= match_count + CNT_W'(1);
        fill <= overlap ? fill_inc : '0;
      end else begin
        fill <= fill_inc;
      end
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized + directed bench for seq_detector_param; a queue-based history model
// predicts every output and a negedge process compares each cycle.
module tb_seq_detector_param;

  localparam int W = 10, PLEN = 4, CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             data = 1'b0, valid = 1'b0, load = 1'b0, overlap = 1'b1, clear = 1'b0;
  logic [PLEN-1:0]  pattern = '0;
  logic             match, match2, armed, armed2;
  logic [W-1:0]     d, d2;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       match_count2;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  // model state
  bit              hist[$];   // hist[0] = newest sampled bit
  int              run;       // counted bits since last restart
  int              cnt;       // unbounded match total
  bit              mexp;
  logic [PLEN-1:0] pat;

  seq_detector_param #(.W(W), .PLEN(PLEN), .CNT_W(CNT_W), .RESET_PAT(4'b1011)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .pattern(pattern), .load(load),
    .overlap(overlap), .clear(clear), .match(match), .d(d), .match_count(match_count),
    .armed(armed));

  seq_detector_param #(.W(W), .PLEN(PLEN), .CNT_W(2), .RESET_PAT(4'b1011)) dut2 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .pattern(pattern), .load(load),
    .overlap(overlap), .clear(clear), .match(match2), .d(d2), .match_count(match_count2),
    .armed(armed2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] hist_vec();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) if (i < hist.size()) v[i] = hist[i];
    return v;
  endfunction

  function automatic void model_reset();
    hist.delete(); run = 0; cnt = 0; mexp = 0; pat = 4'b1011;
  endfunction

  function automatic void push_bit(bit b);
    hist.push_front(b);
    if (hist.size() > W) void'(hist.pop_back());
  endfunction

  // One clock with the current input values; model follows the same edge.
  task automatic step();
    logic [PLEN-1:0] c;
    bit h;
    @(posedge clk);
    if (!rst) model_reset();
    else if (clear) begin
      hist.delete(); run = 0; mexp = 0; cnt = 0;
    end else if (load) begin
      pat = pattern; run = 0; mexp = 0;
      if (valid) push_bit(data);
    end else if (valid) begin
      c[0] = data;
      for (int i = 1; i < PLEN; i++) c[i] = (i - 1 < hist.size()) ? hist[i-1] : 1'b0;
      h = (run >= PLEN - 1) && (c == pat);
      push_bit(data);
      mexp = h;
      if (h) begin
        cnt++;
        run = overlap ? run + 1 : 0;
      end else run++;
    end else mexp = 0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("match", match, mexp);
      chk("d", d, hist_vec());
      chk("match_count", match_count, (cnt > 255) ? 255 : cnt);
      chk("match_count_sat2", match_count2, (cnt > 3) ? 3 : cnt);
      chk("armed", armed, run >= PLEN - 1);
    end
  end

  task automatic feed(input bit b);
    valid = 1'b1; data = b; load = 1'b0; clear = 1'b0;
    step();
  endtask

  task automatic idle(input bit b);
    valid = 1'b0; data = b; load = 1'b0; clear = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0; valid = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [PLEN-1:0] p);
    load = 1'b1; pattern = p; valid = 1'b0; clear = 1'b0;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    logic [6:0]  s7;
    rst = 1'b0;
    model_reset();
    // reset with random activity on inputs
    for (int i = 0; i < 5; i++) begin
      data = 1'($urandom); valid = 1'($urandom);
      step();
    end
    chk_en = 1'b1;
    chk("rst_d", d, 0); chk("rst_match", match, 0);
    chk("rst_count", match_count, 0); chk("rst_armed", armed, 0);
    rst = 1'b1;
    data = 1'b0; valid = 1'b0;

    // overlap stream 1011011 with reset pattern
    overlap = 1'b1; s7 = 7'b1011011; mask = '0;
    for (int i = 0; i < 7; i++) begin feed(s7[6-i]); mask[i] = match; end
    chk("ov_mask", mask, 16'b1001000);
    chk("ov_count", match_count, 2);
    chk("ov_d", d[6:0], 7'b1011011);

    // non-overlap, same stream
    do_clear();
    overlap = 1'b0; mask = '0;
    for (int i = 0; i < 7; i++) begin feed(s7[6-i]); mask[i] = match; end
    chk("nov_mask", mask, 16'b0001000);
    chk("nov_count", match_count, 1);

    // load 0000 mid-stream while valid
    do_clear();
    overlap = 1'b1; mask = '0;
    feed(1); feed(1);
    load = 1'b1; pattern = 4'b0000; valid = 1'b1; data = 1'b0;
    step(); mask[0] = match; load = 1'b0;
    for (int i = 1; i <= 5; i++) begin feed(0); mask[i] = match; end
    chk("load_mask", mask, 16'b110000);

    // saturation: 1111, eight ones
    do_clear();
    do_load(4'b1111); mask = '0;
    for (int i = 0; i < 8; i++) begin feed(1); mask[i] = match; end
    chk("sat_mask", mask, 16'b11111000);
    chk("sat_count2", match_count2, 3);
    chk("sat_count8", match_count, 5);

    // priority and gaps
    do_load(4'b1011);
    clear = 1'b1; load = 1'b1; pattern = 4'b0000; valid = 1'b1; data = 1'b1;
    step(); clear = 1'b0; load = 1'b0;
    chk("clr_d", d, 0);
    mask = '0;
    feed(1); mask[0] = match; feed(0); mask[1] = match;
    for (int i = 2; i < 7; i++) begin idle(1); mask[i] = match; end
    feed(1); mask[7] = match; feed(1); mask[8] = match;
    chk("gap_mask", mask, 16'b100000000);
    chk("gap_count", match_count, 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        data = 1'($urandom); valid = 1'($urandom);
        step();
        rst = 1'b1;
      end else begin
        int r;
        r = $urandom_range(0, 99);
        clear   = (r < 2);
        load    = (r >= 2 && r < 6);
        pattern = PLEN'($urandom);
        valid   = ($urandom_range(0, 9) < 7);
        data    = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 49) == 0) overlap = ~overlap;
        step();
      end
    end
    clear = 1'b0; load = 1'b0; valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
